// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback scheduler for the integer register file.
// Arbitrates NSRC writeback sources onto the single register-file write
// port (one registered write per cycle) and tracks a busy scoreboard of
// destination registers so issue can stall on RAW/WAW hazards.
// Build option: define WB_ARB_RR_EN for round-robin arbitration; when it is
// undefined, fixed priority is used (lowest index wins, source 0 = ALU).
module wb_arbiter #(
  parameter int NSRC = 3,
  parameter int XLEN = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NSRC-1:0]      src_valid,
  input  logic [5*NSRC-1:0]    src_rd,
  input  logic [XLEN*NSRC-1:0] src_data,
  output logic [NSRC-1:0]      src_ready,
  output logic                 rf_we,
  output logic [4:0]           rf_rd,
  output logic [XLEN-1:0]      rf_data,
  input  logic                 iss_valid,
  input  logic [4:0]           iss_rd,
  output logic                 iss_ready,
  input  logic [4:0]           chk_rs1,
  input  logic [4:0]           chk_rs2,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  input  logic                 flush
);

  localparam int PTR_W = (NSRC > 1) ? $clog2(NSRC) : 1;

  // Stage p0: grant and selected source
  logic [NSRC-1:0] gnt_p0;
  logic            xfer_p0;
  logic [4:0]      rd_p0;
  logic [XLEN-1:0] data_p0;

  // Stage p1: registered write port
  logic            vld_p1;
  logic [4:0]      rd_p1;
  logic [XLEN-1:0] data_p1;

  // Scoreboard; bit 0 is held at zero so x0 never reads busy
  logic [31:0]     busy_q;
  logic [31:0]     busy_d;
  logic            iss_fire;

`ifdef WB_ARB_RR_EN
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] gnt_idx_p0;
  logic [PTR_W-1:0] cand_p0;
  logic             found_p0;

  // Round-robin: scan from the slot after the last winner and grant the first valid source.
  always_comb begin
    gnt_p0     = '0;
    gnt_idx_p0 = ptr_q;
    cand_p0    = ptr_q;
    found_p0   = 1'b0;
    for (int k = 1; k <= NSRC; k++) begin
      cand_p0 = PTR_W'((int'(ptr_q) + k) % NSRC);
      if (!found_p0 && src_valid[cand_p0]) begin
        gnt_p0[cand_p0] = 1'b1;
        gnt_idx_p0      = cand_p0;
        found_p0        = 1'b1;
      end
    end
  end

  // Pointer remembers the last granted source; it restarts so source 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= PTR_W'(NSRC - 1);
    end else if (xfer_p0) begin
      ptr_q <= gnt_idx_p0;
    end
  end
`else
  logic found_p0;

  // Fixed priority: the lowest-indexed valid source wins.
  always_comb begin
    gnt_p0   = '0;
    found_p0 = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (!found_p0 && src_valid[i]) begin
        gnt_p0[i] = 1'b1;
        found_p0  = 1'b1;
      end
    end
  end
`endif

  // The grant is only ever raised for a valid source, so any grant is a transfer.
  assign src_ready = gnt_p0;
  assign xfer_p0   = |gnt_p0;

  // Select the winning source's destination and result for the write stage.
  always_comb begin
    rd_p0   = '0;
    data_p0 = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (gnt_p0[i]) begin
        rd_p0   = src_rd[5*i +: 5];
        data_p0 = src_data[XLEN*i +: XLEN];
      end
    end
  end

  // Stage p0 -> p1
  // Register the write port; x0 writebacks are consumed but never raise the enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      rd_p1   <= '0;
      data_p1 <= '0;
    end else if (xfer_p0) begin
      vld_p1  <= (rd_p0 != 5'd0);
      rd_p1   <= rd_p0;
      data_p1 <= data_p0;
    end else begin
      vld_p1  <= 1'b0;
    end
  end

  assign rf_we   = vld_p1;
  assign rf_rd   = rd_p1;
  assign rf_data = data_p1;

  assign iss_ready = ~busy_q[iss_rd];
  assign rs1_busy  = busy_q[chk_rs1];
  assign rs2_busy  = busy_q[chk_rs2];
  assign iss_fire  = iss_valid && iss_ready && (iss_rd != 5'd0);

  // Next scoreboard: commit clears, issue sets (set applied last so it wins), flush wipes all.
  always_comb begin
    busy_d = busy_q;
    if (vld_p1) begin
      busy_d[rd_p1] = 1'b0;
    end
    if (iss_fire) begin
      busy_d[iss_rd] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter. Expected writebacks are queued when the
// stimulus is issued; a negedge monitor pops and compares whenever rf_we is
// high. Combinational outputs are compared inline.
module tb_wb_arbiter;
  localparam int NSRC = 3;
  localparam int XLEN = 64;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } wb_t;

  logic                 clk;
  logic                 rst_n;
  logic [NSRC-1:0]      src_valid;
  logic [5*NSRC-1:0]    src_rd;
  logic [XLEN*NSRC-1:0] src_data;
  logic [NSRC-1:0]      src_ready;
  logic                 rf_we;
  logic [4:0]           rf_rd;
  logic [XLEN-1:0]      rf_data;
  logic                 iss_valid;
  logic [4:0]           iss_rd;
  logic                 iss_ready;
  logic [4:0]           chk_rs1;
  logic [4:0]           chk_rs2;
  logic                 rs1_busy;
  logic                 rs2_busy;
  logic                 flush;

  int  checks = 0;
  int  errors = 0;
  wb_t exp_q[$];

  wb_arbiter #(.NSRC(NSRC), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_valid(src_valid), .src_rd(src_rd), .src_data(src_data),
    .src_ready(src_ready),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic push(input logic [4:0] rd, input logic [63:0] d);
    wb_t w;
    w.rd   = rd;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic set_src(input int i, input logic v, input logic [4:0] rd, input logic [63:0] d);
    src_valid[i]         = v;
    src_rd[5*i +: 5]     = rd;
    src_data[XLEN*i +: XLEN] = d;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write the DUT presents must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rf_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected actual rd=%0d data=%0h required no write", rf_rd, rf_data);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        if (rf_rd !== e.rd || rf_data !== e.data) begin
          errors++;
          $display("FAIL wb_data actual rd=%0d data=%0h required rd=%0d data=%0h",
                   rf_rd, rf_data, e.rd, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] exp_g [3];

    rst_n = 1'b0; src_valid = '0; src_rd = '0; src_data = '0;
    iss_valid = 1'b0; iss_rd = '0; chk_rs1 = '0; chk_rs2 = '0; flush = 1'b0;

    // Reset state
    tick; tick;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_rd", rf_rd, 0);
    chk("rst_rf_data", rf_data, 0);
    chk("rst_ready_none", src_ready, 0);
    rst_n = 1'b1;

    // Single ALU writeback
    set_src(0, 1'b1, 5'd5, 64'hDEAD);
    #1;
    chk("single_gnt", src_ready, 3'b001);
    push(5'd5, 64'hDEAD);
    tick;
    src_valid = '0;
    #1;
    chk("single_we", rf_we, 1);
    chk("single_none_ready", src_ready, 0);
    tick;
    chk("single_we_drop", rf_we, 0);
    chk("single_rd_hold", rf_rd, 5);
    chk("single_data_hold", rf_data, 64'hDEAD);

    // Contention from a freshly reset pointer
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
`ifdef WB_ARB_RR_EN
    exp_g = '{3'b001, 3'b010, 3'b100};
`else
    exp_g = '{3'b001, 3'b001, 3'b001};
`endif
    for (int s = 0; s < NSRC; s++) set_src(s, 1'b1, 5'(s + 1), 64'h100 + 64'(s));
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("contention_gnt", src_ready, exp_g[c]);
      for (int s = 0; s < NSRC; s++)
        if (exp_g[c][s]) push(5'(s + 1), 64'h100 + 64'(s));
      tick;
    end
    src_valid = '0;
    tick;

    // RAW on x7
    iss_valid = 1'b1; iss_rd = 5'd7;
    #1;
    chk("raw_iss_ready", iss_ready, 1);
    tick;
    iss_valid = 1'b0; chk_rs1 = 5'd7;
    set_src(0, 1'b1, 5'd7, 64'h77);
    #1;
    chk("raw_busy_set", rs1_busy, 1);
    push(5'd7, 64'h77);
    tick;
    src_valid = '0;
    #1;
    chk("raw_busy_in_we", rs1_busy, 1);
    chk("raw_we", rf_we, 1);
    tick;
    chk("raw_busy_clr", rs1_busy, 0);

    // WAW on x9, then clear of x9 on the same edge as a set of x10
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick;
    iss_valid = 1'b0; chk_rs2 = 5'd9;
    set_src(0, 1'b1, 5'd9, 64'h99);
    #1;
    chk("waw_iss_ready", iss_ready, 0);
    chk("waw_rs2_busy", rs2_busy, 1);
    push(5'd9, 64'h99);
    tick;
    src_valid = '0; iss_valid = 1'b1; iss_rd = 5'd10;
    #1;
    chk("waw_busy_in_we", rs2_busy, 1);
    chk("waw_iss10_ready", iss_ready, 1);
    tick;
    iss_rd = 5'd9; chk_rs1 = 5'd10;
    #1;
    chk("waw_busy9_clr", rs2_busy, 0);
    chk("waw_x10_set", rs1_busy, 1);
    chk("waw_iss9_ready", iss_ready, 1);
    tick;
    iss_valid = 1'b0;
    #1;
    chk("waw_busy9_reissue", rs2_busy, 1);

    // x0 writeback and x0 issue
    set_src(0, 1'b1, 5'd0, 64'hABC);
    iss_valid = 1'b1; iss_rd = 5'd0;
    #1;
    chk("x0_gnt", src_ready, 3'b001);
    chk("x0_iss_ready", iss_ready, 1);
    tick;
    src_valid = '0; iss_valid = 1'b0; chk_rs1 = 5'd0; chk_rs2 = 5'd0;
    #1;
    chk("x0_no_we", rf_we, 0);
    chk("x0_rs1_busy", rs1_busy, 0);
    chk("x0_rs2_busy", rs2_busy, 0);

    // Flush with concurrent issue and writeback
    iss_valid = 1'b1; iss_rd = 5'd4;
    tick;
    iss_rd = 5'd5;
    tick;
    iss_valid = 1'b0; chk_rs1 = 5'd4; chk_rs2 = 5'd5;
    #1;
    chk("fl_busy4", rs1_busy, 1);
    chk("fl_busy5", rs2_busy, 1);
    flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd6;
    set_src(1, 1'b1, 5'd12, 64'hC0C0);
    #1;
    chk("fl_gnt", src_ready, 3'b010);
    push(5'd12, 64'hC0C0);
    tick;
    flush = 1'b0; iss_valid = 1'b0; src_valid = '0;
    #1;
    chk("fl_clr4", rs1_busy, 0);
    chk("fl_clr5", rs2_busy, 0);
    chk("fl_we", rf_we, 1);
    chk_rs1 = 5'd6; chk_rs2 = 5'd9;
    #1;
    chk("fl_set6_lost", rs1_busy, 0);
    chk("fl_clr9", rs2_busy, 0);
    tick;

    // Async reset while a write is pending
    iss_valid = 1'b1; iss_rd = 5'd20;
    tick;
    iss_valid = 1'b0; chk_rs1 = 5'd20;
    set_src(0, 1'b1, 5'd20, 64'h2020);
    #1;
    chk("ar_busy20", rs1_busy, 1);
    tick;
    src_valid = '0;
    #1;
    chk("ar_we_before", rf_we, 1);
    rst_n = 1'b0;
    #1;
    chk("ar_we", rf_we, 0);
    chk("ar_rd", rf_rd, 0);
    chk("ar_data", rf_data, 0);
    chk("ar_busy_clr", rs1_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    for (int s = 0; s < NSRC; s++) set_src(s, 1'b1, 5'(s + 1), 64'h100 + 64'(s));
    #1;
    chk("ar_first_gnt", src_ready, 3'b001);
    push(5'd1, 64'h100);
    tick;
    src_valid = '0;
    tick;
    tick;

    chk("queue_drained", 64'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
